wb_stage: RTL and testbench
===========================

# wb_stage

Pipelined write-back stage for the pipelined CPU, the successor to the single-cycle ALU/memory result select. It accepts one retiring instruction per cycle from the MEM stage, selects among ALU, load, and link results, and sign/zero-extends sub-word loads. It buffers results in a 2-entry skid buffer with a valid/ready handshake toward the register-file write port. It also exposes the head entry for forwarding and counts retired instructions.

## Interface
- DATA_W, 32: datapath width; legal values are 32 and 64. OFF_W = log2(DATA_W/8).
- REG_AW, 5: register address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_alu_result  in  DATA_W  ALU result.
- in_ram_data  in  DATA_W  raw memory read word.
- in_link  in  DATA_W  PC+4 for jump-and-link.
- in_src  in  2  result select: 0 ALU, 1 memory, 2 link, 3 treated as ALU.
- in_ld_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword.
- in_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0.
- in_byte_off  in  OFF_W  byte offset of the load within in_ram_data.
- in_wen  in  1  instruction writes a register.
- in_wreg  in  REG_AW  destination register.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  register-file port consumes the head.
- wb_wen  out  1  in_wen && wreg!=0 of the head entry.
- wb_waddr  out  REG_AW  head destination.
- wb_wdata  out  DATA_W  head result.
- wb_misalign  out  1  head load was misaligned.
- retired  out  32  count of popped entries.

## Operation
- Push when in_valid && in_ready. The result is computed combinationally from the inputs and written into the tail entry.
- Pop when wb_valid && wb_ready.
- Entries retire in FIFO order. An entry with wb_wen=0 still occupies a slot and still pops.
- Occupancy state is EMPTY(0), ONE(1), or FULL(2). Transitions:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop together: count unchanged.
- in_ready = (count != 2). The next-cycle value is computed from the next count, so it is registered.
- Load extraction when in_src=1:
  - Select lane in_ram_data[8*off +: 8·2^size] and extend to DATA_W per in_ld_unsigned.
  - Size 3 with DATA_W=32 behaves as size 2.
  - Size 2 with DATA_W=32 is the full word; no extension is needed.
- Misalignment: set when off is not a multiple of the access byte count. When misaligned, the lane uses off rounded down to alignment. The flag is stored with the entry.
- For in_src≠1, extraction is bypassed and wb_misalign=0.
- retired increments by 1 on every pop and wraps 0xFFFFFFFF→0.
- Forwarding consumers use wb_valid/wb_wen/wb_waddr/wb_wdata directly. Only the head entry is exposed.

## Timing
- Reset (rst_n low, asynchronous): count=0, wb_valid=0, in_ready=1, wb_wen=0, wb_waddr=0, wb_wdata=0, wb_misalign=0, retired=0.
- Latency: an entry accepted at edge N is visible at wb_valid after edge N (one cycle), provided the buffer was empty or the head popped at edge N.
- Full throughput is one push and one pop per cycle at steady state with wb_ready=1.
- With wb_ready held low, two pushes fill the buffer and in_ready drops the cycle after the second push.
- When full and wb_ready=1, the pop occurs at the edge while no push occurs, because in_ready=0. in_ready returns to 1 the next cycle.
- Reset asserted mid-operation discards both entries. No partial write is emitted.
- wb outputs are stable while wb_valid && !wb_ready.

## Configuration
- WB_SUBWORD_EN defined: sub-word extraction and the misalignment flag are implemented as above.
- WB_SUBWORD_EN undefined: in_ld_size, in_ld_unsigned, and in_byte_off are ignored. The memory result is in_ram_data unmodified, and wb_misalign is tied to 0.

## Structure
- Package wb_pkg holds:
  - the wb_src_e enum (SRC_ALU, SRC_MEM, SRC_LINK);
  - the wb_size_e enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the entry struct (wen, waddr, wdata, misalign).
- Sub-module wb_load_align is purely combinational. It maps raw data, size, unsigned, and offset to extended data and misalign, and is compiled under WB_SUBWORD_EN.
- Top level contains the result mux, the 2-entry buffer with read/write pointers and count, and the retire counter.

## Test plan
- Reset → in_ready=1, wb_valid=0, retired=0; one ALU push of 0x0000_1234 to r3 → next cycle wb_valid=1, wb_waddr=3, wb_wdata=0x1234, wb_wen=1.
- Load byte, ram_data=0x80FF_7F01, off=3, signed → 0xFFFF_FF80; same load unsigned → 0x0000_0080; half at off=2 signed → 0xFFFF_80FF.
- Half load at off=1 → wb_misalign=1 and lane at off=0 (0x7F01 extended); word at off=2 → wb_misalign=1.
- wb_ready=0, three back-to-back pushes → in_ready low after the second push, third held. Release wb_ready → entries pop in order, retired=3, no loss or duplication.
- Write to r0 with in_wen=1 → wb_wen=0 and retired still increments. With retired preloaded to 0xFFFFFFFF via forced pops, the next pop gives retired=0.
- rst_n pulsed low while full → wb_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the write-back stage
package wb_pkg;

    // Storage widths for a buffered entry; narrower configurations zero-pad.
    localparam int WB_DATA_W_MAX = 64;
    localparam int WB_REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } wb_src_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } wb_size_e;

    typedef struct packed {
        logic                     wen;
        logic [WB_REG_AW_MAX-1:0] waddr;
        logic [WB_DATA_W_MAX-1:0] wdata;
        logic                     misalign;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - combinational sub-word load lane select and extension
// Ports: raw_i (memory word), size_i (wb_size_e), unsigned_i, off_i (byte offset)
//        -> data_o (extended result), misalign_o (offset not size-aligned).
// Used by wb_stage only when WB_SUBWORD_EN is defined.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] raw_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misalign_o
);

    logic [1:0]        esize;
    logic [OFF_W-1:0]  low_mask;
    logic [OFF_W-1:0]  aoff;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] sign_bit;
    logic              sgn;
    int                nbits;

    always_comb begin
        esize = size_i;
        // A dword on a 32-bit datapath degenerates to a full word.
        if (DATA_W == 32 && size_i == SZ_D) begin
            esize = SZ_W;
        end

        case (wb_size_e'(esize))
            SZ_B:    low_mask = '0;
            SZ_H:    low_mask = OFF_W'(1);
            SZ_W:    low_mask = OFF_W'(3);
            default: low_mask = OFF_W'(7);
        endcase

        misalign_o = |(off_i & low_mask);
        // Misaligned accesses read the lane at the offset rounded down.
        aoff       = off_i & ~low_mask;
        sh         = raw_i >> {aoff, 3'b000};

        nbits    = 8 << esize;
        mask     = {DATA_W{1'b1}} >> (DATA_W - nbits);
        sign_bit = mask & ~(mask >> 1);
        sgn      = |(sh & sign_bit);
        data_o   = (sh & mask) | ((!unsigned_i && sgn) ? ~mask : '0);
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - pipelined write-back stage with 2-entry skid buffer
// Ports: clk, rst_n (async active-low); in_* MEM-stage instruction with
//        in_valid/in_ready handshake; wb_* head entry toward register file with
//        wb_valid/wb_ready handshake (also used for forwarding); retired count.
// Build option: WB_SUBWORD_EN enables sub-word load extraction and misalign flag;
//        without it the memory result is in_ram_data unmodified.
module wb_stage
    import wb_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int REG_AW = 5,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_ram_data,
    input  logic [DATA_W-1:0] in_link,
    input  logic [1:0]        in_src,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [OFF_W-1:0]  in_byte_off,
    input  logic              in_wen,
    input  logic [REG_AW-1:0] in_wreg,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_wen,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_misalign,
    output logic [31:0]       retired
);

    logic [DATA_W-1:0] mem_data;
    logic              mem_misalign;

`ifdef WB_SUBWORD_EN
    wb_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .raw_i      (in_ram_data),
        .size_i     (in_ld_size),
        .unsigned_i (in_ld_unsigned),
        .off_i      (in_byte_off),
        .data_o     (mem_data),
        .misalign_o (mem_misalign)
    );
`else
    logic unused_subword;
    assign unused_subword = ^{in_ld_size, in_ld_unsigned, in_byte_off};
    assign mem_data       = in_ram_data;
    assign mem_misalign   = 1'b0;
`endif

    wb_entry_t         entry_d;
    logic [DATA_W-1:0] result;
    logic              is_mem;

    always_comb begin
        is_mem = 1'b0;
        case (wb_src_e'(in_src))
            SRC_MEM: begin
                result = mem_data;
                is_mem = 1'b1;
            end
            SRC_LINK: result = in_link;
            default:  result = in_alu_result;
        endcase
        entry_d.wen      = in_wen && (in_wreg != '0);
        entry_d.waddr    = WB_REG_AW_MAX'(in_wreg);
        entry_d.wdata    = WB_DATA_W_MAX'(result);
        entry_d.misalign = is_mem && mem_misalign;
    end

    wb_entry_t   mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] retired_q, retired_d;
    logic        push, pop;
    wb_entry_t   head;

    assign push = in_valid && in_ready_q;
    assign pop  = wb_valid && wb_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        // Registered ready: derived from the count the buffer will hold next cycle.
        in_ready_d = (count_d != 2'd2);
        retired_d  = pop ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            retired_q  <= 32'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= entry_d;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            retired_q  <= retired_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign in_ready    = in_ready_q;
    assign wb_valid    = (count_q != 2'd0);
    assign wb_wen      = head.wen;
    assign wb_waddr    = head.waddr[REG_AW-1:0];
    assign wb_wdata    = head.wdata[DATA_W-1:0];
    assign wb_misalign = head.misalign;
    assign retired     = retired_q;

    // Padding bits of the stored entry beyond the configured widths.
    logic unused_head;
    assign unused_head = ^{head.waddr, head.wdata};

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_ram_data;
    logic [31:0] in_link;
    logic [1:0]  in_src;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_byte_off;
    logic        in_wen;
    logic [4:0]  in_wreg;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_misalign;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_ram_data    (in_ram_data),
        .in_link        (in_link),
        .in_src         (in_src),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .in_byte_off    (in_byte_off),
        .in_wen         (in_wen),
        .in_wreg        (in_wreg),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_wen         (wb_wen),
        .wb_waddr       (wb_waddr),
        .wb_wdata       (wb_wdata),
        .wb_misalign    (wb_misalign),
        .retired        (retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] ram,
                         input logic [31:0] link, input logic [1:0] sz, input logic uns,
                         input logic [1:0] off, input logic wen, input logic [4:0] wreg);
        in_src         = src;
        in_alu_result  = alu;
        in_ram_data    = ram;
        in_link        = link;
        in_ld_size     = sz;
        in_ld_unsigned = uns;
        in_byte_off    = off;
        in_wen         = wen;
        in_wreg        = wreg;
        in_valid       = 1'b1;
    endtask

    // Single load from 0x80FF_7F01 with wb_ready=1; checks the head one cycle later.
    task automatic ld_check(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [1:0] off, input logic [31:0] exp_sub,
                            input logic exp_mis);
        logic [31:0] exp_d;
        logic        exp_m;
`ifdef WB_SUBWORD_EN
        exp_d = exp_sub;
        exp_m = exp_mis;
`else
        exp_d = 32'h80FF_7F01;
        exp_m = 1'b0;
`endif
        drive(2'd1, 32'h0000_DEAD, 32'h80FF_7F01, 32'h0, sz, uns, off, 1'b1, 5'd7);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(wb_valid), 64'd1);
        check({tag, "_data"}, 64'(wb_wdata), 64'(exp_d));
        check({tag, "_mis"}, 64'(wb_misalign), 64'(exp_m));
    endtask

    logic [31:0] base;

    initial begin
        rst_n    = 1'b0;
        wb_ready = 1'b1;
        drive(2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 5'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_wen", 64'(wb_wen), 64'd0);
        check("rst_wdata", 64'(wb_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU result to r3
        drive(2'd0, 32'h0000_1234, 32'hAAAA_AAAA, 32'h5555_5555, 2'd0, 1'b0, 2'd0, 1'b1, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check("alu_valid", 64'(wb_valid), 64'd1);
        check("alu_waddr", 64'(wb_waddr), 64'd3);
        check("alu_wdata", 64'(wb_wdata), 64'h1234);
        check("alu_wen", 64'(wb_wen), 64'd1);
        check("alu_mis", 64'(wb_misalign), 64'd0);
        @(negedge clk);
        check("alu_popped", 64'(wb_valid), 64'd0);
        check("alu_retired", 64'(retired), 64'd1);

        // Link and src=3 select
        drive(2'd2, 32'h1111_1111, 32'h2222_2222, 32'h0000_0104, 2'd0, 1'b0, 2'd1, 1'b1, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("link_wdata", 64'(wb_wdata), 64'h104);
        check("link_mis", 64'(wb_misalign), 64'd0);
        drive(2'd3, 32'h1111_1111, 32'h2222_2222, 32'h0000_0104, 2'd0, 1'b0, 2'd1, 1'b1, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        check("src3_wdata", 64'(wb_wdata), 64'h1111_1111);
        check("src3_waddr", 64'(wb_waddr), 64'd9);

        // Loads
        ld_check("lb_s_off3", 2'd0, 1'b0, 2'd3, 32'hFFFF_FF80, 1'b0);
        ld_check("lb_u_off3", 2'd0, 1'b1, 2'd3, 32'h0000_0080, 1'b0);
        ld_check("lh_s_off2", 2'd1, 1'b0, 2'd2, 32'hFFFF_80FF, 1'b0);
        ld_check("lh_s_off1", 2'd1, 1'b0, 2'd1, 32'h0000_7F01, 1'b1);
        ld_check("lb_s_off0", 2'd0, 1'b0, 2'd0, 32'h0000_0001, 1'b0);
        ld_check("lw_off2", 2'd2, 1'b0, 2'd2, 32'h80FF_7F01, 1'b1);
        ld_check("ld_off0", 2'd3, 1'b0, 2'd0, 32'h80FF_7F01, 1'b0);
        @(negedge clk);

        // Backpressure: three pushes with wb_ready low
        base     = retired;
        wb_ready = 1'b0;
        drive(2'd0, 32'hA000_0001, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd10);
        @(negedge clk);
        check("bp_ready1", 64'(in_ready), 64'd1);
        drive(2'd0, 32'hB000_0002, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd11);
        @(negedge clk);
        check("bp_ready2", 64'(in_ready), 64'd0);
        check("bp_head_a", 64'(wb_wdata), 64'hA000_0001);
        drive(2'd0, 32'hC000_0003, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd12);
        @(negedge clk);
        check("bp_held_ready", 64'(in_ready), 64'd0);
        check("bp_stable_data", 64'(wb_wdata), 64'hA000_0001);
        check("bp_stable_addr", 64'(wb_waddr), 64'd10);
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp_head_b", 64'(wb_wdata), 64'hB000_0002);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_head_c", 64'(wb_wdata), 64'hC000_0003);
        check("bp_head_c_addr", 64'(wb_waddr), 64'd12);
        @(negedge clk);
        check("bp_empty", 64'(wb_valid), 64'd0);
        check("bp_retired3", 64'(retired - base), 64'd3);

        // r0 write and retired wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        @(negedge clk);
        check("wrap_preload", 64'(retired), 64'hFFFF_FFFF);
        drive(2'd0, 32'h0000_0055, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("r0_valid", 64'(wb_valid), 64'd1);
        check("r0_wen", 64'(wb_wen), 64'd0);
        @(negedge clk);
        check("wrap_retired", 64'(retired), 64'd0);

        // Asynchronous reset while full
        wb_ready = 1'b0;
        drive(2'd0, 32'h0000_0077, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd4);
        @(negedge clk);
        drive(2'd0, 32'h0000_0088, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(wb_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_wdata", 64'(wb_wdata), 64'd0);
        check("arst_retired", 64'(retired), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(wb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
